// File: rtl/spi_wb_target.sv
// rtl/spi_wb_target.sv - SPI mode-0 target bridging initiator frames to 32-bit Wishbone cycles
// Optional feature: define SPI_WB_AUTOINC_EN for multi-word frames with address auto-increment.
module spi_wb_target #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_i,
    input  logic        spi_data_i,
    output logic        spi_data_o,
    output logic        bus_err_o
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} frame_state_t;
    typedef enum logic {WB_IDLE, WB_BUSY} wb_state_t;

    frame_state_t frame_state;
    wb_state_t    wb_state;

    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_d, cs_d;
    logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_q;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_in, addr_q, tx_sr, rd_data;
    logic        is_write;
    logic [3:0]  sel_q;
    logic        miso_q;
    logic [7:0]  timer;
    logic        wb_stale;

    logic [31:0] shifted;
    logic        req_valid, req_we;
    logic [31:0] req_adr;

    assign spi_data_o = miso_q & ~spi_cs_i;

    // Edge pulses are registered; mosi_q is delayed by the same amount so it lines up with sck_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
            sck_rise  <= 1'b0;
            sck_fall  <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk_i};
            cs_sync   <= {cs_sync[0], spi_cs_i};
            mosi_sync <= {mosi_sync[0], spi_data_i};
            sck_d     <= sck_sync[1];
            cs_d      <= cs_sync[1];
            sck_rise  <= sck_sync[1] & ~sck_d;
            sck_fall  <= ~sck_sync[1] & sck_d;
            cs_rise   <= cs_sync[1] & ~cs_d;
            cs_fall   <= ~cs_sync[1] & cs_d;
            mosi_q    <= mosi_sync[1];
        end
    end

    always_comb begin
        shifted   = {shift_in[30:0], mosi_q};
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = addr_q;
        if (sck_rise && !cs_rise && !cs_fall) begin
            case (frame_state)
                S_ADDR: begin
                    if (bit_cnt == 5'd31 && !is_write) begin
                        req_valid = 1'b1;
                        req_adr   = shifted;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == 5'd31) begin
                        if (is_write) begin
                            req_valid = 1'b1;
                            req_we    = 1'b1;
                        end
`ifdef SPI_WB_AUTOINC_EN
                        else begin
                            req_valid = 1'b1;
                            req_adr   = addr_q + 32'd4;
                        end
`endif
                    end
                end
`ifdef SPI_WB_AUTOINC_EN
                S_DUMMY: begin
                    if (bit_cnt == 5'd7) begin
                        req_valid = 1'b1;
                        req_adr   = addr_q + 32'd4;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_state <= S_IDLE;
            wb_state    <= WB_IDLE;
            adr_o       <= 32'h0;
            dat_o       <= 32'h0;
            we_o        <= 1'b0;
            sel_o       <= 4'h0;
            stb_o       <= 1'b0;
            cyc_o       <= 1'b0;
            bus_err_o   <= 1'b0;
            bit_cnt     <= 5'd0;
            shift_in    <= 32'h0;
            addr_q      <= 32'h0;
            tx_sr       <= 32'h0;
            rd_data     <= 32'h0;
            is_write    <= 1'b0;
            sel_q       <= 4'h0;
            miso_q      <= 1'b0;
            timer       <= 8'd0;
            wb_stale    <= 1'b0;
        end else begin
            case (wb_state)
                WB_IDLE: begin
                    if (req_valid) begin
                        adr_o    <= req_adr;
                        we_o     <= req_we;
                        sel_o    <= sel_q;
                        if (req_we)
                            dat_o <= shifted;
                        cyc_o    <= 1'b1;
                        stb_o    <= 1'b1;
                        timer    <= 8'd0;
                        wb_stale <= 1'b0;
                        wb_state <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (ack_i) begin
                        cyc_o    <= 1'b0;
                        stb_o    <= 1'b0;
                        wb_state <= WB_IDLE;
                        if (!we_o && !wb_stale)
                            rd_data <= dat_i;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        cyc_o    <= 1'b0;
                        stb_o    <= 1'b0;
                        wb_state <= WB_IDLE;
                        if (!wb_stale) begin
                            bus_err_o <= 1'b1;
                            if (!we_o)
                                rd_data <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
            endcase

            // A cycle outliving its frame still finishes on the bus, but its result is dropped.
            if (cs_rise && wb_state == WB_BUSY)
                wb_stale <= 1'b1;

            if (cs_rise) begin
                frame_state <= S_IDLE;
                bit_cnt     <= 5'd0;
                miso_q      <= 1'b0;
            end else if (cs_fall) begin
                frame_state <= S_CMD;
                bit_cnt     <= 5'd0;
                tx_sr       <= 32'h0;
                miso_q      <= 1'b0;
                bus_err_o   <= 1'b0;
            end else begin
                case (frame_state)
                    S_CMD: begin
                        if (sck_rise) begin
                            shift_in <= shifted;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                is_write    <= shifted[7];
                                sel_q       <= (shifted[3:0] == 4'h0) ? 4'hF : shifted[3:0];
                                bit_cnt     <= 5'd0;
                                frame_state <= S_ADDR;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            shift_in <= shifted;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
                                addr_q      <= shifted;
                                bit_cnt     <= 5'd0;
                                frame_state <= is_write ? S_DATA : S_DUMMY;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                tx_sr       <= rd_data;
                                bit_cnt     <= 5'd0;
                                frame_state <= S_DATA;
`ifdef SPI_WB_AUTOINC_EN
                                addr_q      <= addr_q + 32'd4;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (sck_rise) begin
                            shift_in <= shifted;
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31) begin
`ifdef SPI_WB_AUTOINC_EN
                                if (!is_write)
                                    tx_sr <= rd_data;
                                addr_q <= addr_q + 32'd4;
`else
                                frame_state <= S_DONE;
`endif
                            end
                        end else if (sck_fall) begin
                            miso_q <= tx_sr[31];
                            tx_sr  <= {tx_sr[30:0], 1'b0};
                        end
                    end
                    default: miso_q <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_wb_target.sv
// tb/tb_spi_wb_target.sv - scoreboard bench for spi_wb_target with a word-level memory reference model
module tb_spi_wb_target;
    localparam int TIMEOUT = 32;
    localparam int HALF    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr_o, dat_o, dat_i;
    logic        we_o, stb_o, cyc_o, ack_i;
    logic [3:0]  sel_o;
    logic        spi_sck = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, bus_err_o;

    always #5 clk = ~clk;

    spi_wb_target #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
        .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i),
        .spi_clk_i(spi_sck), .spi_cs_i(spi_cs), .spi_data_i(spi_mosi),
        .spi_data_o(spi_miso), .bus_err_o(bus_err_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          chk_len;
    } wb_exp_t;

    wb_exp_t     exp_wb[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] tx_words[4];
    logic [31:0] rx_words[4];
    logic        pre_or;
    int          tests = 0;
    int          fails = 0;
    int          ack_lat = 0;
    int          wait_cnt = 0;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wishbone memory responder; ack_lat < 0 means never acknowledge.
    initial begin
        ack_i = 1'b0;
        dat_i = 32'h0;
        forever begin
            @(negedge clk);
            if (ack_i) begin
                ack_i = 1'b0;
                wait_cnt = 0;
            end else if (cyc_o && stb_o) begin
                if (ack_lat >= 0 && wait_cnt >= ack_lat) begin
                    ack_i = 1'b1;
                    if (we_o) slave_mem[adr_o] = dat_o;
                    else dat_i = slave_mem.exists(adr_o) ? slave_mem[adr_o] : fill(adr_o);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Bus monitor: pops one expectation per cycle start, checks abandoned-cycle length.
    initial begin
        logic    cyc_prev;
        int      cyc_len;
        wb_exp_t cur;
        bit      cur_valid;
        cyc_prev = 1'b0; cyc_len = 0; cur_valid = 0;
        forever begin
            @(negedge clk);
            if (cyc_o && !cyc_prev) begin
                cyc_len = 0;
                if (exp_wb.size() == 0) begin
                    tests++; fails++; cur_valid = 0;
                    $display("FAIL unexpected_wb: got cycle adr %h we %b, expected none", adr_o, we_o);
                end else begin
                    cur = exp_wb.pop_front();
                    cur_valid = 1;
                    check("wb_adr", adr_o, cur.adr);
                    check("wb_we", we_o, cur.we);
                    check("wb_sel", sel_o, cur.sel);
                    check("wb_stb", stb_o, 1);
                    if (cur.we) check("wb_dat", dat_o, cur.dat);
                end
            end
            if (cyc_o) cyc_len++;
            if (!cyc_o && cyc_prev && cur_valid && cur.chk_len)
                check("wb_timeout_len", cyc_len, TIMEOUT);
            cyc_prev = cyc_o;
        end
    end

    task automatic spi_xfer(input logic [7:0] cmd, input logic [31:0] addr, input int nwords, input int cut_bits);
        int dstart;
        int total;
        dstart = cmd[7] ? 40 : 48;
        total  = (cut_bits > 0) ? cut_bits : dstart + 32 * nwords;
        pre_or = 1'b0;
        for (int k = 0; k < 4; k++) rx_words[k] = 32'h0;
        spi_cs = 1'b0;
        wait_clk(6);
        for (int i = 0; i < total; i++) begin
            logic b;
            if (i < 8) b = cmd[7 - i];
            else if (i < 40) b = addr[39 - i];
            else if (i < dstart) b = 1'b0;
            else b = tx_words[(i - dstart) / 32][31 - ((i - dstart) % 32)];
            spi_mosi = b;
            wait_clk(HALF);
            if (i >= dstart) rx_words[(i - dstart) / 32][31 - ((i - dstart) % 32)] = spi_miso;
            else pre_or = pre_or | spi_miso;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
        if (cut_bits == 0) wait_clk(60);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr, input int nwords, input int lat);
        logic [3:0]  sel;
        bit          noack;
        wb_exp_t     e;
        int          nwb;
        int          nrx;
        logic [31:0] exp_rx[4];
        noack   = (lat < 0);
        ack_lat = lat;
        sel     = (cmd[3:0] == 4'h0) ? 4'hF : cmd[3:0];
`ifdef SPI_WB_AUTOINC_EN
        nwb = cmd[7] ? nwords : nwords + 2;
        nrx = nwords;
`else
        nwb = 1;
        nrx = 1;
`endif
        for (int k = 0; k < nwb; k++) begin
            e.we = cmd[7]; e.adr = addr + 32'(4 * k); e.sel = sel;
            e.dat = cmd[7] ? tx_words[k] : 32'h0; e.chk_len = noack;
            exp_wb.push_back(e);
            if (cmd[7] && !noack) ref_mem[e.adr] = tx_words[k];
        end
        for (int k = 0; k < 4; k++)
            exp_rx[k] = (k < nrx) ? (noack ? 32'hFFFF_FFFF : ref_rd(addr + 32'(4 * k))) : 32'h0;
        spi_xfer(cmd, addr, nwords, 0);
        check("miso_zero_before_data", pre_or, 0);
        if (!cmd[7])
            for (int k = 0; k < nwords; k++) check("miso_word", rx_words[k], exp_rx[k]);
        check("bus_err", bus_err_o, noack);
        spi_cs = 1'b1;
        wait_clk(10);
        check("miso_cs_high", spi_miso, 0);
        check("bus_err_sticky", bus_err_o, noack);
        check("wb_queue_drained", exp_wb.size(), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addrs[4];
        wb_exp_t     e;
        int          n;
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0104;
        addrs[2] = 32'h0000_0200; addrs[3] = 32'hFFFF_FFFC;

        wait_clk(3);
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_miso", spi_miso, 0);
        rst = 1'b0;
        wait_clk(5);

        tx_words[0] = 32'hCAFE_F00D;
        run_frame(8'h8F, 32'h1000_0010, 1, 2);

        slave_mem[32'h2000_0000] = 32'h1234_5678;
        ref_mem[32'h2000_0000]   = 32'h1234_5678;
        run_frame(8'h03, 32'h2000_0000, 1, 5);

        run_frame(8'h0A, 32'h3000_0000, 1, -1);

        // Frame aborted after 20 address bits must not reach the bus.
        ack_lat = 0;
        spi_xfer(8'h8F, 32'h4000_0000, 1, 28);
        spi_cs = 1'b1;
        wait_clk(60);
        check("abort_no_wb", exp_wb.size(), 0);
        tx_words[0] = 32'h0BAD_BEEF;
        run_frame(8'h85, 32'h4000_0000, 1, 1);

        // Reset pulsed while a read is waiting on the bus.
        ack_lat = -1;
        e.we = 1'b0; e.adr = 32'h5000_0000; e.sel = 4'h1; e.dat = 32'h0; e.chk_len = 0;
        exp_wb.push_back(e);
        spi_xfer(8'h01, 32'h5000_0000, 1, 41);
        n = 0;
        while (!cyc_o && n < 50) begin
            wait_clk(1);
            n++;
        end
        check("cyc_before_rst", cyc_o, 1);
        rst = 1'b1;
        wait_clk(1);
        check("rst_mid_cyc", cyc_o, 0);
        check("rst_mid_stb", stb_o, 0);
        check("rst_mid_adr", adr_o, 0);
        check("rst_mid_we", we_o, 0);
        check("rst_mid_sel", sel_o, 0);
        check("rst_mid_miso", spi_miso, 0);
        rst = 1'b0;
        wait_clk(20);
        spi_cs = 1'b1;
        wait_clk(20);
        check("post_rst_bus_err", bus_err_o, 0);
        tx_words[0] = 32'h600D_F00D;
        run_frame(8'h8C, 32'h6000_0008, 1, 0);

        // Multi-word write frame: auto-increment streams, otherwise extra bits are ignored.
        tx_words[0] = 32'h1111_1111; tx_words[1] = 32'h2222_2222; tx_words[2] = 32'h3333_3333;
`ifdef SPI_WB_AUTOINC_EN
        run_frame(8'h8F, 32'h0000_0100, 3, 1);
`else
        run_frame(8'h8F, 32'h0000_0100, 2, 1);
`endif

        for (int t = 0; t < 20; t++) begin
            logic [7:0] cmd;
            int         lat;
            cmd = 8'($urandom_range(0, 255));
            lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 6));
            for (int k = 0; k < 4; k++) tx_words[k] = $urandom;
            run_frame(cmd, addrs[$urandom_range(0, 3)], int'($urandom_range(1, 2)), lat);
        end

        check("final_queue_empty", exp_wb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
